// File: rtl/rsa_uart_host_if.sv
// Bundles the request/response handshake, the UART byte ports and the busy
// flag of rsa_uart_host.
//   master : host view (drives req_ready, resp_*, tx_data*, busy)
//   slave  : environment view (drives req_valid/e/m, tx_data_ack, rx_data*)
interface rsa_uart_host_if #(
    parameter int unsigned BITS = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [BITS-1:0] req_e;
    logic [BITS-1:0] req_m;
    logic            resp_valid;
    logic [BITS-1:0] resp_data;
    logic            resp_error;
    logic [7:0]      tx_data;
    logic            tx_data_valid;
    logic            tx_data_ack;
    logic [7:0]      rx_data;
    logic            rx_data_fresh;
    logic            busy;

    modport master (
        input  req_valid, req_e, req_m, tx_data_ack, rx_data, rx_data_fresh,
        output req_ready, resp_valid, resp_data, resp_error, tx_data, tx_data_valid, busy
    );

    modport slave (
        output req_valid, req_e, req_m, tx_data_ack, rx_data, rx_data_fresh,
        input  req_ready, resp_valid, resp_data, resp_error, tx_data, tx_data_valid, busy
    );
endinterface

// File: rtl/rsa_uart_host.sv
// Host-side initiator for the UART RSA byte protocol. Accepts {e, m}, sends
// 2*BITS/8 bytes MSB first over the uart byte interface, then assembles the
// BITS/8-byte reply (MSB first) into resp_data with a one-cycle resp_valid.
// Ports: clk, rst (async active-low), bus (rsa_uart_host_if.master):
//   req_valid/req_ready/req_e/req_m  request handshake
//   resp_valid/resp_data/resp_error  result pulse, data held until next pulse
//   tx_data/tx_data_valid/tx_data_ack, rx_data/rx_data_fresh  uart byte ports
//   busy                             high outside IDLE
// Optional: define RSA_HOST_TIMEOUT_EN to abort RECV after TIMEOUT_CYCLES
// without a byte, reporting the partial result with resp_error=1.
module rsa_uart_host #(
    parameter int unsigned BITS           = 64,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input logic             clk,
    input logic             rst,
    rsa_uart_host_if.master bus
);
    localparam int unsigned NTX   = (2 * BITS) / 8;
    localparam int unsigned NRX   = BITS / 8;
    localparam int unsigned CNT_W = $clog2(NTX + 1);

    // Elaboration-time guard on parameter values
    if ((BITS % 8) != 0 || BITS < 16 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("rsa_uart_host: BITS must be a multiple of 8 (>= 16), TIMEOUT_CYCLES nonzero");
    end

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, RECV, DONE} state_t;

    state_t            state, state_nx;
    logic [2*BITS-1:0] shift, shift_nx;
    logic [BITS-1:0]   result, result_nx;
    logic [BITS-1:0]   resp_data, resp_data_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [7:0]        tx_data, tx_data_nx;
    logic              tx_valid, tx_valid_nx;
    logic              resp_valid, resp_valid_nx;
    logic              resp_error, resp_error_nx;
    logic              req_ready, req_ready_nx;
    logic              busy, busy_nx;
    logic              ack_hit;

`ifdef RSA_HOST_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr, tmr_nx;
    logic             tmr_expired;
    assign tmr_expired = (tmr == TMR_W'(TIMEOUT_CYCLES - 1));
`endif

    // An ack only counts while a byte is actually on offer
    assign ack_hit = tx_valid && bus.tx_data_ack;

    // Next-state and next-register values
    always_comb begin
        state_nx      = state;
        shift_nx      = shift;
        result_nx     = result;
        resp_data_nx  = resp_data;
        cnt_nx        = cnt;
        tx_data_nx    = tx_data;
        tx_valid_nx   = tx_valid;
        resp_valid_nx = 1'b0;
        resp_error_nx = resp_error;
`ifdef RSA_HOST_TIMEOUT_EN
        tmr_nx        = '0;
`endif
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    shift_nx    = {bus.req_e, bus.req_m};
                    result_nx   = '0;
                    cnt_nx      = '0;
                    // First byte goes out the cycle after accept
                    tx_data_nx  = bus.req_e[BITS-1 -: 8];
                    tx_valid_nx = 1'b1;
                    state_nx    = SEND;
                end
            end
            SEND, WAIT_ACK: begin
                if (state == SEND) begin
                    tx_data_nx  = shift[2*BITS-1 -: 8];
                    tx_valid_nx = 1'b1;
                    state_nx    = WAIT_ACK;
                end
                if (ack_hit) begin
                    tx_valid_nx = 1'b0;
                    shift_nx    = shift << 8;
                    if (cnt == CNT_W'(NTX - 1)) begin
                        cnt_nx   = '0;
                        state_nx = RECV;
                    end else begin
                        cnt_nx   = cnt + CNT_W'(1);
                        state_nx = SEND;
                    end
                end
            end
            RECV: begin
                if (bus.rx_data_fresh) begin
                    result_nx = {result[BITS-9:0], bus.rx_data};
                    if (cnt == CNT_W'(NRX - 1)) begin
                        resp_data_nx  = {result[BITS-9:0], bus.rx_data};
                        resp_valid_nx = 1'b1;
                        resp_error_nx = 1'b0;
                        cnt_nx        = '0;
                        state_nx      = DONE;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
`ifdef RSA_HOST_TIMEOUT_EN
                else if (tmr_expired) begin
                    resp_data_nx  = result;
                    resp_valid_nx = 1'b1;
                    resp_error_nx = 1'b1;
                    cnt_nx        = '0;
                    state_nx      = DONE;
                end else begin
                    tmr_nx = tmr + TMR_W'(1);
                end
`endif
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        req_ready_nx = (state_nx == IDLE);
        busy_nx      = (state_nx != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift      <= '0;
            result     <= '0;
            resp_data  <= '0;
            cnt        <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
`ifdef RSA_HOST_TIMEOUT_EN
            tmr        <= '0;
`endif
        end else begin
            state      <= state_nx;
            shift      <= shift_nx;
            result     <= result_nx;
            resp_data  <= resp_data_nx;
            cnt        <= cnt_nx;
            tx_data    <= tx_data_nx;
            tx_valid   <= tx_valid_nx;
            resp_valid <= resp_valid_nx;
            resp_error <= resp_error_nx;
            req_ready  <= req_ready_nx;
            busy       <= busy_nx;
`ifdef RSA_HOST_TIMEOUT_EN
            tmr        <= tmr_nx;
`endif
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.busy          = busy;
    assign bus.resp_valid    = resp_valid;
    assign bus.resp_data     = resp_data;
    assign bus.resp_error    = resp_error;
    assign bus.tx_data       = tx_data;
    assign bus.tx_data_valid = tx_valid;
endmodule
